l2_tlb_miss_arbiter: RTL and testbench

Shares one L2 TLB lookup port and one page-table-walker (PTW) request port between the instruction L1 TLB (requester 0) and the data L1 TLB (requester 1). It accepts one L1 miss at a time and looks it up in the L2 TLB. On an L2 miss it issues the walk to the PTW, refills the L2 TLB with the result, and returns the PTE to the requester that owns the miss. The block sits between the two L1 TLB request paths and the shared L2 TLB/PTW.

---
 rtl/l2_tlb_miss_arbiter_pkg.sv | 23 ++
 rtl/l2_tlb_miss_arbiter_if.sv | 69 ++++++
 rtl/l2_tlb_req_grant.sv | 34 +++
 rtl/l2_tlb_miss_arbiter.sv | 151 +++++++++++++++
 tb/tb_l2_tlb_miss_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_tlb_miss_arbiter_pkg.sv
// Shared types and constants for the L2 TLB miss arbiter.
// Optional build macro L2TLB_ARB_RR_EN selects round-robin grant (see l2_tlb_req_grant).
package l2_tlb_miss_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 27;
   localparam int unsigned PTE_W_DEF  = 64;

   localparam logic ITLB = 1'b0;
   localparam logic DTLB = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOOKUP   = 3'd1,
      ST_PTW_REQ  = 3'd2,
      ST_PTW_WAIT = 3'd3,
      ST_RESP     = 3'd4
   } arb_state_t;

   function automatic logic [1:0] req_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/l2_tlb_miss_arbiter_if.sv
// Bundle of L1 request/response, L2 TLB and PTW signals around the miss arbiter.
// slave = arbiter view, master = surrounding L1/L2/PTW view. Macro L2TLB_ARB_RR_EN has no effect here.
interface l2_tlb_miss_arbiter_if
   import l2_tlb_miss_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned PTE_W  = PTE_W_DEF
);

   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*ADDR_W-1:0] req_addr;
   logic [1:0]          req_store;
   logic [1:0]          req_pum;
   logic [1:0]          req_mxr;
   logic [3:0]          req_prv;

   logic [1:0]          resp_valid;
   logic [PTE_W-1:0]    resp_pte;
   logic                resp_pf;

   logic                l2_req_valid;
   logic [ADDR_W-1:0]   l2_req_addr;
   logic                l2_resp_valid;
   logic                l2_resp_hit;
   logic [PTE_W-1:0]    l2_resp_pte;
   logic                l2_refill_valid;
   logic [ADDR_W-1:0]   l2_refill_addr;
   logic [PTE_W-1:0]    l2_refill_pte;

   logic                ptw_req_valid;
   logic                ptw_req_ready;
   logic [ADDR_W-1:0]   ptw_req_bits_addr;
   logic                ptw_req_bits_fetch;
   logic                ptw_req_bits_store;
   logic                ptw_req_bits_pum;
   logic                ptw_req_bits_mxr;
   logic [1:0]          ptw_req_bits_prv;
   logic                ptw_resp_valid;
   logic                ptw_resp_pf;
   logic [PTE_W-1:0]    ptw_resp_pte;

   logic                flush;

   modport slave (
      input  req_valid, req_addr, req_store, req_pum, req_mxr, req_prv,
      input  l2_resp_valid, l2_resp_hit, l2_resp_pte,
      input  ptw_req_ready, ptw_resp_valid, ptw_resp_pf, ptw_resp_pte,
      input  flush,
      output req_ready, resp_valid, resp_pte, resp_pf,
      output l2_req_valid, l2_req_addr,
      output l2_refill_valid, l2_refill_addr, l2_refill_pte,
      output ptw_req_valid, ptw_req_bits_addr, ptw_req_bits_fetch, ptw_req_bits_store,
      output ptw_req_bits_pum, ptw_req_bits_mxr, ptw_req_bits_prv
   );

   modport master (
      output req_valid, req_addr, req_store, req_pum, req_mxr, req_prv,
      output l2_resp_valid, l2_resp_hit, l2_resp_pte,
      output ptw_req_ready, ptw_resp_valid, ptw_resp_pf, ptw_resp_pte,
      output flush,
      input  req_ready, resp_valid, resp_pte, resp_pf,
      input  l2_req_valid, l2_req_addr,
      input  l2_refill_valid, l2_refill_addr, l2_refill_pte,
      input  ptw_req_valid, ptw_req_bits_addr, ptw_req_bits_fetch, ptw_req_bits_store,
      input  ptw_req_bits_pum, ptw_req_bits_mxr, ptw_req_bits_prv
   );

endinterface

// File: rtl/l2_tlb_req_grant.sv
// Two-way grant between ITLB (0) and DTLB (1) with a preference pointer.
// L2TLB_ARB_RR_EN defined: pointer flips after each accept; undefined: DTLB always preferred.
module l2_tlb_req_grant
   import l2_tlb_miss_arbiter_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       grant_idx
);

   logic favour;

   always_ff @(posedge clock) begin
      if (reset) begin
         favour <= DTLB;
      end else if (accept) begin
`ifdef L2TLB_ARB_RR_EN
         favour <= ~grant_idx;
`else
         favour <= DTLB;
`endif
      end
   end

   // The preferred requester wins on contention; a lone requester always wins.
   always_comb begin
      grant_idx = valid[favour] ? favour : ~favour;
      grant     = (|valid) ? req_onehot(grant_idx) : 2'b00;
   end

endmodule

// File: rtl/l2_tlb_miss_arbiter.sv
// Serialises ITLB/DTLB misses through one L2 TLB lookup and one PTW walk port.
// Grant mode set by macro L2TLB_ARB_RR_EN (round-robin) in l2_tlb_req_grant; default is DTLB priority.
module l2_tlb_miss_arbiter
   import l2_tlb_miss_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned PTE_W  = PTE_W_DEF
) (
   input logic                  clock,
   input logic                  reset,
   l2_tlb_miss_arbiter_if.slave bus
);

   arb_state_t        state;
   logic              owner;
   logic [ADDR_W-1:0] addr;
   logic              fetch;
   logic              store;
   logic              pum;
   logic              mxr;
   logic [1:0]        prv;
   logic              drop;
   logic              l2_req;
   logic              ptw_req;
   logic [1:0]        resp_vec;
   logic [PTE_W-1:0]  pte;
   logic              pf;

   logic [1:0]        grant;
   logic              grant_idx;
   logic [1:0]        ready;
   logic              accept;
   logic              refill;

   l2_tlb_req_grant u_grant (
      .clock     (clock),
      .reset     (reset),
      .valid     (bus.req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign ready  = (state == ST_IDLE && !bus.flush && !reset) ? grant : 2'b00;
   assign accept = |(bus.req_valid & ready);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         owner    <= ITLB;
         addr     <= '0;
         fetch    <= 1'b0;
         store    <= 1'b0;
         pum      <= 1'b0;
         mxr      <= 1'b0;
         prv      <= '0;
         drop     <= 1'b0;
         l2_req   <= 1'b0;
         ptw_req  <= 1'b0;
         resp_vec <= '0;
         pte      <= '0;
         pf       <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  owner  <= grant_idx;
                  fetch  <= (grant_idx == ITLB);
                  addr   <= grant_idx ? bus.req_addr[2*ADDR_W-1 -: ADDR_W] : bus.req_addr[ADDR_W-1:0];
                  store  <= bus.req_store[grant_idx];
                  pum    <= bus.req_pum[grant_idx];
                  mxr    <= bus.req_mxr[grant_idx];
                  prv    <= grant_idx ? bus.req_prv[3:2] : bus.req_prv[1:0];
                  drop   <= 1'b0;
                  l2_req <= 1'b1;
                  state  <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               l2_req <= 1'b0;
               if (bus.flush) begin
                  state <= ST_IDLE;
               end else if (bus.l2_resp_valid) begin
                  if (bus.l2_resp_hit) begin
                     pte      <= bus.l2_resp_pte;
                     pf       <= 1'b0;
                     resp_vec <= req_onehot(owner);
                     state    <= ST_RESP;
                  end else begin
                     ptw_req <= 1'b1;
                     state   <= ST_PTW_REQ;
                  end
               end
            end
            // An accepted walk cannot be recalled, so a coincident flush becomes a drop.
            ST_PTW_REQ: begin
               if (bus.ptw_req_ready) begin
                  ptw_req <= 1'b0;
                  drop    <= bus.flush;
                  state   <= ST_PTW_WAIT;
               end else if (bus.flush) begin
                  ptw_req <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            ST_PTW_WAIT: begin
               if (bus.ptw_resp_valid) begin
                  if (drop || bus.flush) begin
                     drop  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     pte      <= bus.ptw_resp_pte;
                     pf       <= bus.ptw_resp_pf;
                     resp_vec <= req_onehot(owner);
                     state    <= ST_RESP;
                  end
               end else if (bus.flush) begin
                  drop <= 1'b1;
               end
            end
            ST_RESP: begin
               resp_vec <= '0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Refill rides the PTW response cycle, so it is decoded rather than registered.
   assign refill = (state == ST_PTW_WAIT) && bus.ptw_resp_valid && !bus.ptw_resp_pf &&
                   !drop && !bus.flush && !reset;

   assign bus.req_ready          = ready;
   assign bus.resp_valid         = resp_vec & ~{2{bus.flush}};
   assign bus.resp_pte           = pte;
   assign bus.resp_pf            = pf;
   assign bus.l2_req_valid       = l2_req;
   assign bus.l2_req_addr        = addr;
   assign bus.l2_refill_valid    = refill;
   assign bus.l2_refill_addr     = addr;
   assign bus.l2_refill_pte      = refill ? bus.ptw_resp_pte : '0;
   assign bus.ptw_req_valid      = ptw_req;
   assign bus.ptw_req_bits_addr  = addr;
   assign bus.ptw_req_bits_fetch = fetch;
   assign bus.ptw_req_bits_store = store;
   assign bus.ptw_req_bits_pum   = pum;
   assign bus.ptw_req_bits_mxr   = mxr;
   assign bus.ptw_req_bits_prv   = prv;

endmodule

// File: tb/tb_l2_tlb_miss_arbiter.sv
// Scoreboard bench for l2_tlb_miss_arbiter; expectations follow L2TLB_ARB_RR_EN if defined.
module tb_l2_tlb_miss_arbiter;

   localparam int unsigned AW = 27;
   localparam int unsigned PW = 64;
`ifdef L2TLB_ARB_RR_EN
   localparam logic RR = 1'b1;
`else
   localparam logic RR = 1'b0;
`endif

   typedef struct {
      logic [1:0]    owner;
      logic [PW-1:0] pte;
      logic          pf;
   } resp_exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [PW-1:0] pte;
   } refill_exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   l2_tlb_miss_arbiter_if #(.ADDR_W(AW), .PTE_W(PW)) bus ();

   l2_tlb_miss_arbiter #(.ADDR_W(AW), .PTE_W(PW)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned ptw_cycles = 0;
   int unsigned refills = 0;
   resp_exp_t   resp_q[$];
   refill_exp_t refill_q[$];

   logic [3:0] prv_all = 4'b0111;
   logic [1:0] pum_all = 2'b10;
   logic [1:0] mxr_all = 2'b01;

   task automatic check(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] sel(input logic g);
      return g ? 2'b10 : 2'b01;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      resp_exp_t   e;
      refill_exp_t r;
      if (bus.ptw_req_valid) ptw_cycles++;
      if (bus.l2_refill_valid) refills++;
      if (bus.resp_valid != 2'b00) begin
         if (resp_q.size() == 0) begin
            check("resp_unexpected", {62'd0, bus.resp_valid}, 64'd0);
         end else begin
            e = resp_q.pop_front();
            check("resp_owner", {62'd0, bus.resp_valid}, {62'd0, e.owner});
            check("resp_pte", bus.resp_pte, e.pte);
            check("resp_pf", {63'd0, bus.resp_pf}, {63'd0, e.pf});
         end
      end
      if (bus.l2_refill_valid) begin
         if (refill_q.size() == 0) begin
            check("refill_unexpected", 64'd1, 64'd0);
         end else begin
            r = refill_q.pop_front();
            check("refill_addr", {37'd0, bus.l2_refill_addr}, {37'd0, r.addr});
            check("refill_pte", bus.l2_refill_pte, r.pte);
         end
      end
   end

   // Starts in IDLE, ends in IDLE; L2 answers one cycle after the lookup strobe.
   task automatic run_hit(input logic [1:0] vpat, input logic g, input logic [AW-1:0] vpn,
                          input logic [PW-1:0] pte);
      int unsigned c0;
      c0 = ptw_cycles;
      bus.req_valid = vpat;
      bus.req_addr  = {vpn, vpn};
      bus.req_store = 2'b00;
      #1;
      check("grant", {62'd0, bus.req_ready}, {62'd0, sel(g)});
      step();
      check("l2_req_strobe", {63'd0, bus.l2_req_valid}, 64'd1);
      check("l2_req_addr", {37'd0, bus.l2_req_addr}, {37'd0, vpn});
      step();
      check("l2_req_one_cycle", {63'd0, bus.l2_req_valid}, 64'd0);
      bus.l2_resp_valid = 1'b1;
      bus.l2_resp_hit   = 1'b1;
      bus.l2_resp_pte   = pte;
      resp_q.push_back('{owner: sel(g), pte: pte, pf: 1'b0});
      step();
      bus.l2_resp_valid = 1'b0;
      bus.l2_resp_hit   = 1'b0;
      check("hit_latency", {62'd0, bus.resp_valid}, {62'd0, sel(g)});
      step();
      bus.req_valid = 2'b00;
      check("hit_no_ptw", 64'(ptw_cycles - c0), 64'd0);
   endtask

   task automatic run_miss(input logic g, input logic [AW-1:0] vpn, input logic st,
                           input int unsigned hold, input logic [PW-1:0] pte,
                           input logic pf, input logic flush_wait);
      int unsigned r0;
      r0 = refills;
      bus.req_valid = sel(g);
      bus.req_addr  = {vpn, vpn};
      bus.req_store = {st, st};
      #1;
      check("miss_grant", {62'd0, bus.req_ready}, {62'd0, sel(g)});
      step();
      bus.req_valid = 2'b00;
      step();
      bus.l2_resp_valid = 1'b1;
      bus.l2_resp_hit   = 1'b0;
      step();
      bus.l2_resp_valid = 1'b0;
      check("ptw_prv", {62'd0, bus.ptw_req_bits_prv}, {62'd0, (g ? prv_all[3:2] : prv_all[1:0])});
      check("ptw_pum", {63'd0, bus.ptw_req_bits_pum}, {63'd0, pum_all[g]});
      check("ptw_mxr", {63'd0, bus.ptw_req_bits_mxr}, {63'd0, mxr_all[g]});
      for (int unsigned i = 0; i <= hold; i++) begin
         check("ptw_valid_held", {63'd0, bus.ptw_req_valid}, 64'd1);
         check("ptw_addr", {37'd0, bus.ptw_req_bits_addr}, {37'd0, vpn});
         check("ptw_store", {63'd0, bus.ptw_req_bits_store}, {63'd0, st});
         check("ptw_fetch", {63'd0, bus.ptw_req_bits_fetch}, {63'd0, !g});
         if (i == hold) bus.ptw_req_ready = 1'b1;
         step();
      end
      bus.ptw_req_ready = 1'b0;
      check("ptw_valid_drop", {63'd0, bus.ptw_req_valid}, 64'd0);
      if (flush_wait) begin
         bus.flush = 1'b1;
         step();
         bus.flush = 1'b0;
      end else begin
         step();
      end
      bus.ptw_resp_valid = 1'b1;
      bus.ptw_resp_pf    = pf;
      bus.ptw_resp_pte   = pte;
      if (!flush_wait) resp_q.push_back('{owner: sel(g), pte: pte, pf: pf});
      if (!flush_wait && !pf) refill_q.push_back('{addr: vpn, pte: pte});
      #1;
      check("refill_same_cycle", {63'd0, bus.l2_refill_valid}, {63'd0, (!flush_wait && !pf)});
      step();
      bus.ptw_resp_valid = 1'b0;
      bus.ptw_resp_pf    = 1'b0;
      check("miss_resp", {62'd0, bus.resp_valid}, {62'd0, (flush_wait ? 2'b00 : sel(g))});
      if (!flush_wait) step();
      check("refill_count", 64'(refills - r0), {63'd0, (!flush_wait && !pf)});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst                = 1'b1;
      bus.req_valid      = '0;
      bus.req_addr       = '0;
      bus.req_store      = '0;
      bus.req_pum        = pum_all;
      bus.req_mxr        = mxr_all;
      bus.req_prv        = prv_all;
      bus.l2_resp_valid  = 1'b0;
      bus.l2_resp_hit    = 1'b0;
      bus.l2_resp_pte    = '0;
      bus.ptw_req_ready  = 1'b0;
      bus.ptw_resp_valid = 1'b0;
      bus.ptw_resp_pf    = 1'b0;
      bus.ptw_resp_pte   = '0;
      bus.flush          = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      check("rst_l2_req", {63'd0, bus.l2_req_valid}, 64'd0);
      check("rst_ptw_req", {63'd0, bus.ptw_req_valid}, 64'd0);
      check("rst_resp", {62'd0, bus.resp_valid}, 64'd0);
      check("rst_refill", {63'd0, bus.l2_refill_valid}, 64'd0);
      check("rst_ready_idle", {62'd0, bus.req_ready}, 64'd0);
      bus.req_valid = 2'b11;
      #1;
      check("rst_favours_dtlb", {62'd0, bus.req_ready}, 64'd2);
      bus.req_valid = 2'b00;

      // ITLB hit
      run_hit(2'b01, 1'b0, 27'h1234, 64'hABCD);
      // DTLB store miss with delayed PTW accept
      run_miss(1'b1, 27'h7FFFFFF, 1'b1, 4, 64'h55, 1'b0, 1'b0);
      // walk fault: no refill, pf returned
      run_miss(1'b0, 27'h2AA, 1'b0, 0, 64'h99, 1'b1, 1'b0);
      // flush while waiting, then immediate next request
      run_miss(1'b1, 27'h0ABC, 1'b0, 1, 64'h77, 1'b0, 1'b1);
      run_hit(2'b01, 1'b0, 27'h0DEF, 64'h1234_5678);

      // reset while the walk request is held
      bus.req_valid = 2'b10;
      bus.req_addr  = {27'h333, 27'h333};
      step();
      bus.req_valid = 2'b00;
      step();
      bus.l2_resp_valid = 1'b1;
      bus.l2_resp_hit   = 1'b0;
      step();
      bus.l2_resp_valid = 1'b0;
      check("pre_reset_ptw", {63'd0, bus.ptw_req_valid}, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("post_reset_ptw", {63'd0, bus.ptw_req_valid}, 64'd0);
      bus.req_valid = 2'b10;
      #1;
      check("post_reset_ready", {62'd0, bus.req_ready}, 64'd2);
      bus.req_valid = 2'b00;
      bus.ptw_resp_valid = 1'b1;
      bus.ptw_resp_pte   = 64'h1;
      #1;
      check("stale_ptw_refill", {63'd0, bus.l2_refill_valid}, 64'd0);
      step();
      bus.ptw_resp_valid = 1'b0;
      check("stale_ptw_resp", {62'd0, bus.resp_valid}, 64'd0);

      // contention every cycle; pointer was reset to DTLB
      run_hit(2'b11, 1'b1, 27'h100, 64'h1001);
      run_hit(2'b11, RR ? 1'b0 : 1'b1, 27'h200, 64'h2002);
      run_hit(2'b11, 1'b1, 27'h300, 64'h3003);

      step();
      check("resp_q_drained", 64'(resp_q.size()), 64'd0);
      check("refill_q_drained", 64'(refill_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
